a2d_intf: RTL and testbench

//  Conversion responder for the motion controller's A2D handshake (strt_cnv/chnnl -> cnv_cmplt/res).

---
 rtl/a2d_pkg.sv | 29 ++
 rtl/spi_mstr16.sv | 65 ++++++
 rtl/a2d_intf.sv | 112 +++++++++++
 tb/tb_a2d_intf.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion responder and its SPI master.
// Timing constants are positions of the SCLK divider within one SCLK period.
package a2d_pkg;

    localparam int unsigned SCLK_DIV = 32;
    localparam int unsigned FRM_BITS = 16;
    localparam int unsigned RES_W    = 12;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned DIV_W    = $clog2(SCLK_DIV);
    localparam int unsigned CNT_W    = $clog2(FRM_BITS + 1);

    // Preload sits 9 counts before the wrap so SCLK first falls 8 clk after SS_n drops.
    localparam logic [DIV_W-1:0] DIV_PRELOAD = 5'b10111;
    localparam logic [DIV_W-1:0] SHFT_PT     = 5'b10001;
    localparam logic [DIV_W-1:0] END_PT      = 5'b11110;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FRM1 = 3'd1,
        GAP  = 3'd2,
        FRM2 = 3'd3,
        DONE = 3'd4
    } a2d_state_t;

    function automatic logic [FRM_BITS-1:0] a2d_cmd(input logic [CH_W-1:0] chnnl);
        return {2'b00, chnnl, 11'h000};
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// Single-frame SPI master: one i_wrt pulse runs one 16-bit exchange, SCLK idling high.
// SS_n trails the internal frame-active flag by one clock at both ends of the frame.
module spi_mstr16
    import a2d_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wrt,
    input  logic [FRM_BITS-1:0] i_cmd,
    input  logic                i_miso,
    output logic                o_done,
    output logic [FRM_BITS-1:0] o_rd_data,
    output logic                o_ss_n,
    output logic                o_sclk,
    output logic                o_mosi
);

    logic                r_active;
    logic                r_ss_n;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [FRM_BITS-1:0] r_shft;
    logic                w_done;
    logic                w_shift;

    // Frame ends on the SCLK high phase after the 16th sample, before a 17th fall.
    assign w_done  = r_active && (r_bit_cnt == CNT_W'(FRM_BITS)) && (r_div == END_PT);
    assign w_shift = r_active && (r_div == SHFT_PT);

    // NOTE: every register here uses <= so all of them see pre-edge values of one another.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_ss_n    <= 1'b1;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shft    <= '0;
        end else begin
            r_ss_n <= ~r_active;
            if (i_wrt) begin
                r_active  <= 1'b1;
                r_shft    <= i_cmd;
                r_div     <= DIV_PRELOAD;
                r_bit_cnt <= '0;
            end else if (r_active) begin
                r_div <= r_div + DIV_W'(1);
                if (w_shift) begin
                    r_shft    <= {r_shft[FRM_BITS-2:0], i_miso};
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
                if (w_done) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

    // Async reset clears r_active, so SCLK and MOSI fall back to idle without a clock.
    assign o_sclk    = ~r_active | r_div[DIV_W-1];
    assign o_mosi    = r_active & r_shft[FRM_BITS-1];
    assign o_ss_n    = r_ss_n;
    assign o_done    = w_done;
    assign o_rd_data = r_shft;

endmodule

// File: rtl/a2d_intf.sv
// A2D handshake responder: sequences a command frame, a 32-clk SS_n gap and a data frame,
// then publishes the low 12 bits of the second frame as the conversion result.
module a2d_intf
    import a2d_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt_cnv,
    input  logic [CH_W-1:0]  chnnl,
    output logic             cnv_cmplt,
    output logic [RES_W-1:0] res,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO
);

    a2d_state_t          r_state;
    a2d_state_t          w_nxt_state;
    logic [CH_W-1:0]     r_chnnl;
    logic [DIV_W-1:0]    r_gap_cnt;
    logic [RES_W-1:0]    r_res;
    logic                r_cnv_cmplt;
    logic                w_wrt;
    logic                w_accept;
    logic [FRM_BITS-1:0] w_cmd;
    logic                w_spi_done;
    logic [FRM_BITS-1:0] w_rd_data;
    logic [FRM_BITS-RES_W-1:0] w_unused_msbs;

    assign w_accept      = (r_state == IDLE) && strt_cnv;
    assign w_unused_msbs = w_rd_data[FRM_BITS-1:RES_W];

    // The first frame loads on the accepting edge, before r_chnnl holds the new channel.
    assign w_cmd = (r_state == IDLE) ? a2d_cmd(chnnl) : a2d_cmd(r_chnnl);

    spi_mstr16 u_spi (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wrt     (w_wrt),
        .i_cmd     (w_cmd),
        .i_miso    (MISO),
        .o_done    (w_spi_done),
        .o_rd_data (w_rd_data),
        .o_ss_n    (SS_n),
        .o_sclk    (SCLK),
        .o_mosi    (MOSI)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        w_nxt_state = r_state;
        w_wrt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (strt_cnv) begin
                    w_wrt       = 1'b1;
                    w_nxt_state = FRM1;
                end
            end
            FRM1: begin
                if (w_spi_done) begin
                    w_nxt_state = GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == DIV_W'(SCLK_DIV - 1)) begin
                    w_wrt       = 1'b1;
                    w_nxt_state = FRM2;
                end
            end
            FRM2: begin
                if (w_spi_done) begin
                    w_nxt_state = DONE;
                end
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chnnl     <= '0;
            r_gap_cnt   <= '0;
            r_res       <= '0;
            r_cnv_cmplt <= 1'b0;
        end else begin
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + DIV_W'(1) : '0;
            if (w_accept) begin
                r_chnnl     <= chnnl;
                r_cnv_cmplt <= 1'b0;
            end
            if (r_state == DONE) begin
                r_res       <= w_rd_data[RES_W-1:0];
                r_cnv_cmplt <= 1'b1;
            end
        end
    end

    assign res       = r_res;
    assign cnv_cmplt = r_cnv_cmplt;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: an ADC model on the SPI pins plus frame/timing monitors;
// expected results come from per-channel ADC values and the frame timing rules.
module tb_a2d_intf;

    localparam int CLK_PER_BIT = 32;
    localparam int PORCH       = 8;
    localparam int FRAME_CLK   = PORCH + 16 * CLK_PER_BIT;
    localparam int LATENCY     = 2 * FRAME_CLK + CLK_PER_BIT + 2;
    localparam int MAX_FRM     = 64;

    typedef struct {
        int          falls;
        logic [15:0] word;
        int          porch;
        int          gap;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO = 1'b0;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [11:0] adc_val [8];
    frame_t      frames [MAX_FRM];
    int          n_frames = 0;
    int          ss_falls = 0;
    int          sclk_edges = 0;
    int          sclk_hi_edges = 0;
    int          mosi_viol = 0;

    a2d_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model and pin monitor, sampled half a clock away from the DUT's active edge.
    logic        p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
    logic        chk_after = 1'b0, mosi_at_rise = 1'b0;
    logic [15:0] f_word = '0, tx_word = '0;
    logic [2:0]  last_ch = '0;
    int          f_falls = 0, f_rises = 0, f_porch = -1, f_gap = -1;
    int          ss_fall_cyc = 0, ss_rise_cyc = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_ss = 1'b1; p_sclk = 1'b1; p_mosi = 1'b0;
            chk_after = 1'b0; f_falls = 0; f_rises = 0; ss_rise_cyc = -1;
        end else begin
            if (chk_after) begin
                if (MOSI !== mosi_at_rise) mosi_viol++;
                chk_after = 1'b0;
            end
            if (SCLK !== p_sclk) sclk_edges++;
            if (SS_n && p_ss && (SCLK !== p_sclk)) sclk_hi_edges++;
            if (!SS_n && p_ss) begin
                ss_falls++;
                ss_fall_cyc = cyc;
                f_falls = 0; f_rises = 0; f_word = '0; f_porch = -1;
                f_gap = (ss_rise_cyc < 0) ? -1 : cyc - ss_rise_cyc;
                tx_word = {4'h0, adc_val[last_ch]};
            end
            if (!SS_n && !p_ss) begin
                if (p_sclk && !SCLK) begin
                    if (f_falls == 0) f_porch = cyc - ss_fall_cyc;
                    if (f_falls < 16) MISO = tx_word[15 - f_falls];
                    f_falls++;
                end
                if (!p_sclk && SCLK) begin
                    if (MOSI !== p_mosi) mosi_viol++;
                    mosi_at_rise = MOSI;
                    chk_after = 1'b1;
                    f_word = {f_word[14:0], MOSI};
                    f_rises++;
                end
            end
            if (SS_n && !p_ss) begin
                ss_rise_cyc = cyc;
                if (n_frames < MAX_FRM) frames[n_frames] = '{f_falls, f_word, f_porch, f_gap};
                n_frames++;
                if (f_rises == 16) last_ch = f_word[13:11];
            end
            p_ss = SS_n; p_sclk = SCLK; p_mosi = MOSI;
        end
    end

    // One full conversion; with disturb set, chnnl wanders and extra strt_cnv pulses land
    // in frame 1, the gap and frame 2.
    task automatic run_conv(input logic [2:0] ch, input bit disturb);
        int          t0, rp0, res_chg;
        bit          got;
        logic [11:0] old_res;
        logic [15:0] exp_cmd;
        old_res = res;
        rp0     = n_frames;
        res_chg = 0;
        got     = 1'b0;
        exp_cmd = 16'(int'(ch) * 2048);
        @(posedge clk); #1;
        strt_cnv = 1'b1;
        chnnl    = ch;
        t0       = cyc;
        for (int k = 1; k <= LATENCY + 50; k++) begin
            @(posedge clk); #1;
            strt_cnv = 1'b0;
            if (k == 1) check("cmplt_clr", 32'(cnv_cmplt), 32'd0);
            if (cnv_cmplt) begin
                got = 1'b1;
                break;
            end
            if (res !== old_res) res_chg++;
            if (disturb) begin
                chnnl = 3'($urandom);
                if (k == 100 || k == 535 || k == 800) strt_cnv = 1'b1;
            end
        end
        check("cmplt_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency", 32'(cyc - t0), 32'(LATENCY));
            check("res", 32'(res), 32'(adc_val[ch]));
        end
        check("res_hold", 32'(res_chg), 32'd0);
        repeat (2) @(negedge clk);
        check("frame_cnt", 32'(n_frames - rp0), 32'd2);
        if (n_frames - rp0 >= 2 && rp0 + 1 < MAX_FRM) begin
            for (int f = 0; f < 2; f++) begin
                check("sclk_falls", 32'(frames[rp0 + f].falls), 32'd16);
                check("mosi_cmd", 32'(frames[rp0 + f].word), 32'(exp_cmd));
                check("porch", 32'(frames[rp0 + f].porch), 32'(PORCH));
            end
            check("gap", 32'(frames[rp0 + 1].gap), 32'(CLK_PER_BIT));
        end
    endtask

    initial begin
        int  base;
        bit  found;
        logic [2:0] ch;
        adc_val[0] = 12'h000; adc_val[1] = 12'hFFF;
        adc_val[2] = 12'h800; adc_val[3] = 12'h7FF;
        adc_val[4] = 12'hA5C;
        for (int i = 5; i < 8; i++) adc_val[i] = 12'($urandom);
        rst_n = 1'b0; strt_cnv = 1'b0; chnnl = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset / idle
        repeat (100) @(posedge clk);
        #1;
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("idle_sclk_edges", 32'(sclk_edges), 32'd0);
        check("idle_ss_falls", 32'(ss_falls), 32'd0);

        // Channel 4, known data
        run_conv(3'd4, 1'b0);

        // All channels back to back, each start while cnv_cmplt is still high
        for (int c = 0; c < 8; c++) run_conv(3'(c), 1'b0);

        // Disturbed conversion: no restart, latched channel, single completion
        ch = 3'($urandom);
        run_conv(ch, 1'b1);
        base = ss_falls;
        repeat (200) @(posedge clk);
        #1;
        check("no_restart", 32'(ss_falls - base), 32'd0);
        check("cmplt_held", 32'(cnv_cmplt), 32'd1);

        // Async reset in the middle of frame 2
        @(posedge clk); #1;
        strt_cnv = 1'b1; chnnl = 3'd5;
        @(posedge clk); #1;
        strt_cnv = 1'b0;
        base  = ss_falls;
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (ss_falls >= base + 2 && !SS_n && !SCLK) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_setup", 32'(found), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ss_n", 32'(SS_n), 32'd1);
        check("arst_sclk", 32'(SCLK), 32'd1);
        check("arst_cmplt", 32'(cnv_cmplt), 32'd0);
        check("arst_res", 32'(res), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        run_conv(3'd6, 1'b0);

        // Timing hygiene over the whole run
        check("mosi_stable", 32'(mosi_viol), 32'd0);
        check("sclk_ss_high", 32'(sclk_hi_edges), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
